// File: rtl/gray_to_binary_rr_scheduler.sv
// Round-robin front end that time-shares one combinational Gray-to-binary converter
// between NUM_REQ requesters and returns tagged results on a single response channel.
module gray_to_binary_rr_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                           Clock_In,
    input  logic                           Reset_In,
    input  logic [NUM_REQ-1:0]             Req_Valid_In,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  Req_Gray_Data_In,
    output logic [NUM_REQ-1:0]             Req_Ready_Out,
    output logic                           Conv_Enable_Out,
    output logic [DATA_WIDTH-1:0]          Conv_Gray_Data_Out,
    input  logic [DATA_WIDTH-1:0]          Conv_Binary_Data_In,
    output logic                           Resp_Valid_Out,
    input  logic                           Resp_Ready_In,
    output logic [$clog2(NUM_REQ)-1:0]     Resp_Id_Out,
    output logic [DATA_WIDTH-1:0]          Resp_Binary_Data_Out,
    output logic                           Busy_Out
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] op_q, op_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;

    logic                  win_found;
    logic [ID_W-1:0]       win_id;
    logic [DATA_WIDTH-1:0] win_data;
    logic [ID_W:0]         sum;

    // Scan from the farthest offset down so the nearest valid requester to ptr_q wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        sum       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(NUM_REQ)) begin
                sum = sum - (ID_W + 1)'(NUM_REQ);
            end
            if (Req_Valid_In[sum[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win_id) begin
                win_data = Req_Gray_Data_In[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        id_d    = id_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    op_d    = win_data;
                    id_d    = win_id;
                    ptr_d   = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    res_d   = Conv_Binary_Data_In;
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (Resp_Ready_In) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            id_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            id_q    <= id_d;
            res_q   <= res_d;
        end
    end

    // Ready is gated by reset so every output reads zero while reset is held.
    always_comb begin
        Req_Ready_Out = '0;
        if (state_q == ST_IDLE && win_found && !Reset_In) begin
            Req_Ready_Out[win_id] = 1'b1;
        end
    end

    assign Conv_Enable_Out      = (state_q == ST_CONVERT);
    assign Conv_Gray_Data_Out   = (state_q == ST_CONVERT) ? op_q : '0;
    assign Resp_Valid_Out       = (state_q == ST_RESPOND);
    assign Resp_Id_Out          = id_q;
    assign Resp_Binary_Data_Out = res_q;
    assign Busy_Out             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gray_to_binary_rr_scheduler.sv
// Directed bench for the round-robin Gray-to-binary scheduler: one SETTLE_CYCLES=1
// instance for arbitration/backpressure/reset and one SETTLE_CYCLES=3 instance.
module tb_gray_to_binary_rr_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]   req_valid = '0;
    logic [127:0] req_data  = '0;
    logic [3:0]   req_ready;
    logic         conv_en;
    logic [31:0]  conv_gray;
    logic [31:0]  conv_bin;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [1:0]   resp_id;
    logic [31:0]  resp_data;
    logic         busy;

    logic [3:0]   s3_req_valid = '0;
    logic [127:0] s3_req_data  = '0;
    logic [3:0]   s3_req_ready;
    logic         s3_conv_en;
    logic [31:0]  s3_conv_gray;
    logic [31:0]  s3_conv_bin;
    logic         s3_resp_valid;
    logic         s3_resp_ready = 1'b0;
    logic [1:0]   s3_resp_id;
    logic [31:0]  s3_resp_data;
    logic         s3_busy;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] g2b(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // External converter model; a recognisable junk value when disabled exposes mistimed capture.
    assign conv_bin    = conv_en    ? g2b(conv_gray)    : 32'hDEAD_BEEF;
    assign s3_conv_bin = s3_conv_en ? g2b(s3_conv_gray) : 32'hDEAD_BEEF;

    gray_to_binary_rr_scheduler #(.NUM_REQ(4), .DATA_WIDTH(32), .SETTLE_CYCLES(1)) dut (
        .Clock_In(clk), .Reset_In(rst),
        .Req_Valid_In(req_valid), .Req_Gray_Data_In(req_data), .Req_Ready_Out(req_ready),
        .Conv_Enable_Out(conv_en), .Conv_Gray_Data_Out(conv_gray), .Conv_Binary_Data_In(conv_bin),
        .Resp_Valid_Out(resp_valid), .Resp_Ready_In(resp_ready), .Resp_Id_Out(resp_id),
        .Resp_Binary_Data_Out(resp_data), .Busy_Out(busy)
    );

    gray_to_binary_rr_scheduler #(.NUM_REQ(4), .DATA_WIDTH(32), .SETTLE_CYCLES(3)) dut3 (
        .Clock_In(clk), .Reset_In(rst),
        .Req_Valid_In(s3_req_valid), .Req_Gray_Data_In(s3_req_data), .Req_Ready_Out(s3_req_ready),
        .Conv_Enable_Out(s3_conv_en), .Conv_Gray_Data_Out(s3_conv_gray), .Conv_Binary_Data_In(s3_conv_bin),
        .Resp_Valid_Out(s3_resp_valid), .Resp_Ready_In(s3_resp_ready), .Resp_Id_Out(s3_resp_id),
        .Resp_Binary_Data_Out(s3_resp_data), .Busy_Out(s3_busy)
    );

    typedef struct {
        int          id;
        logic [31:0] gray;
        logic [31:0] bin;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        if (req_ready == '0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: ready never asserted within 20 cycles", nm);
        end
    endtask

    task automatic wait_resp(input string nm);
        int n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        if (!resp_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: response never valid within 20 cycles", nm);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        s3_req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        req_data[v.id*32 +: 32] = v.gray;
        #1;
        chk($sformatf("vec_ready_id%0d", v.id), 64'(req_ready), 64'(1) << v.id);
        tick();
        req_valid = '0;
        chk("vec_conv_en", 64'(conv_en), 64'd1);
        chk("vec_conv_gray", 64'(conv_gray), 64'(v.gray));
        chk("vec_busy", 64'(busy), 64'd1);
        chk("vec_ready_convert", 64'(req_ready), 64'd0);
        tick();
        chk("vec_resp_valid", 64'(resp_valid), 64'd1);
        chk("vec_resp_id", 64'(resp_id), 64'(v.id));
        chk($sformatf("vec_resp_data_%h", v.gray), 64'(resp_data), 64'(v.bin));
        chk("vec_conv_gray_off", 64'(conv_gray), 64'd0);
        tick();
        chk("vec_resp_done", 64'(resp_valid), 64'd0);
        chk("vec_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rr_bin [4];
        int cnt;
        int n;

        vecs[0] = '{0, 32'h0000_0002, 32'h0000_0003};
        vecs[1] = '{2, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[2] = '{2, 32'hC000_0000, 32'h8000_0000};
        vecs[3] = '{2, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{3, 32'h0000_0008, 32'h0000_000F};
        vecs[5] = '{1, 32'hFFFF_FFFF, 32'hAAAA_AAAA};
        vecs[6] = '{1, 32'h0000_0005, 32'h0000_0006};
        rr_bin  = '{32'h1, 32'h3, 32'h7, 32'hF};

        // Reset values
        #2;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_conv_en", 64'(conv_en), 64'd0);
        chk("rst_conv_gray", 64'(conv_gray), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        do_reset();

        // Single transactions; ready held high in advance must not disturb anything
        resp_ready = 1'b1;
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // All four requesters valid: strict rotation 0..3, then wrap back to 0
        do_reset();
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'(1) << i;
        req_valid = 4'b1111;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            wait_ready("rr_wait_ready");
            chk($sformatf("rr_grant_%0d", k), 64'(req_ready), 64'(1) << (k % 4));
            tick();
            wait_resp("rr_wait_resp");
            chk($sformatf("rr_id_%0d", k), 64'(resp_id), 64'(k % 4));
            chk($sformatf("rr_data_%0d", k), 64'(resp_data), 64'(rr_bin[k % 4]));
            tick();
        end
        req_valid = '0;

        // Backpressure: response held stable while req 1 waits
        resp_ready = 1'b0;
        req_valid[0] = 1'b1;
        req_data[31:0] = 32'h0000_0004;
        #1;
        chk("bp_grant0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        wait_resp("bp_wait_resp");
        req_valid[1] = 1'b1;
        req_data[63:32] = 32'h0000_0003;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_id", 64'(resp_id), 64'd0);
            chk("bp_data", 64'(resp_data), 64'h7);
            chk("bp_ready_blocked", 64'(req_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_grant1_next_idle", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        wait_resp("bp_wait_resp1");
        chk("bp_id1", 64'(resp_id), 64'd1);
        chk("bp_data1", 64'(resp_data), 64'h2);
        tick();

        // Reset mid-CONVERT with pointer at 2 (last grant was req 1)
        req_valid[2] = 1'b1;
        req_data[95:64] = 32'h0000_0010;
        #1;
        chk("mr_grant2", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        chk("mr_in_convert", 64'(conv_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("mr_conv_en", 64'(conv_en), 64'd0);
        chk("mr_conv_gray", 64'(conv_gray), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_resp_valid", 64'(resp_valid), 64'd0);
        chk("mr_resp_id", 64'(resp_id), 64'd0);
        chk("mr_resp_data", 64'(resp_data), 64'd0);
        req_valid = 4'b1010;
        req_data[63:32] = 32'h0000_0006;
        #1;
        chk("mr_ready_in_reset", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_first_grant", 64'(req_ready), 64'b0010);
        tick();
        req_valid[1] = 1'b0;
        wait_resp("mr_wait_resp");
        chk("mr_resp_id1", 64'(resp_id), 64'd1);
        chk("mr_resp_data1", 64'(resp_data), 64'h4);
        tick();
        chk("mr_second_grant", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0;
        wait_resp("mr_wait_resp3");
        tick();

        // SETTLE_CYCLES=3 instance
        s3_resp_ready = 1'b1;
        s3_req_valid[0] = 1'b1;
        s3_req_data[31:0] = 32'h0000_0003;
        #1;
        chk("s3_grant", 64'(s3_req_ready), 64'b0001);
        tick();
        s3_req_valid = '0;
        cnt = 0;
        n = 0;
        while (!s3_resp_valid && n < 20) begin
            if (s3_conv_en) cnt++;
            chk("s3_resp_early", 64'(s3_resp_valid), 64'd0);
            tick();
            n++;
        end
        chk("s3_enable_cycles", 64'(cnt), 64'd3);
        chk("s3_resp_valid", 64'(s3_resp_valid), 64'd1);
        chk("s3_conv_en_off", 64'(s3_conv_en), 64'd0);
        chk("s3_resp_id", 64'(s3_resp_id), 64'd0);
        chk("s3_resp_data", 64'(s3_resp_data), 64'h2);
        tick();
        chk("s3_idle", 64'(s3_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_to_binary_rr_scheduler.md
Name: gray_to_binary_rr_scheduler

Overview:
Round-robin scheduler that shares one combinational Gray_to_Binary_Converter_32_Bit instance between NUM_REQ requesters. It accepts Gray words over per-requester valid/ready handshakes and drives the converter's enable and data inputs. After a programmable settle time it captures the converted result and returns it on a single valid/ready response channel tagged with the requester ID. It sits between the pointer-synchronisation logic of multiple clients and the shared converter datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, Gray/binary word width; must match converter
SETTLE_CYCLES, 1, cycles converter enable is held before result capture (>=1; 0 illegal, elaboration $error)

Ports:
Clock_In  input  1  single clock, rising edge
Reset_In  input  1  asynchronous, active-high reset
Req_Valid_In  input  NUM_REQ  request valid, one bit per requester
Req_Gray_Data_In  input  NUM_REQ*DATA_WIDTH  packed Gray words; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
Req_Ready_Out  output  NUM_REQ  one-hot accept; transfer when valid & ready at rising edge
Conv_Enable_Out  output  1  to converter Enable_In
Conv_Gray_Data_Out  output  DATA_WIDTH  to converter Gray_Data_In
Conv_Binary_Data_In  input  DATA_WIDTH  from converter Binary_Data_Out
Resp_Valid_Out  output  1  response valid
Resp_Ready_In  input  1  response consumer ready
Resp_Id_Out  output  clog2(NUM_REQ)  index of requester owning response
Resp_Binary_Data_Out  output  DATA_WIDTH  captured binary result
Busy_Out  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock (Clock_In); Reset_In is asynchronous, active-high.
- Reset values: state IDLE, RR pointer 0, settle counter 0, all outputs 0 (Req_Ready_Out, Conv_Enable_Out, Conv_Gray_Data_Out, Resp_Valid_Out, Resp_Id_Out, Resp_Binary_Data_Out, Busy_Out).
- States: IDLE -> CONVERT -> RESPOND -> IDLE.
- IDLE:
  - Winner = first i with Req_Valid_In[i]=1, searching cyclically from the RR pointer.
  - Req_Ready_Out is combinational: one-hot at the winner, 0 if no valid bit is set. Ready is never asserted outside IDLE.
  - On the accepting edge: capture the winner's data into the operand register, capture the winner ID, set pointer = (winner+1) mod NUM_REQ, clear the counter, go to CONVERT.
- CONVERT:
  - Conv_Enable_Out=1; Conv_Gray_Data_Out = operand register.
  - The counter increments each edge. On the edge where counter == SETTLE_CYCLES-1, capture Conv_Binary_Data_In into Resp_Binary_Data_Out and go to RESPOND.
- RESPOND:
  - Resp_Valid_Out=1. Resp_Id_Out and Resp_Binary_Data_Out are held stable until Resp_Valid_Out & Resp_Ready_In at an edge, then go to IDLE.
  - Conv_Enable_Out=0 (converter output Z, ignored).
- Conv_Gray_Data_Out = 0 outside CONVERT.
- Latency: accept edge E0 -> Resp_Valid_Out high after edge E(SETTLE_CYCLES). Minimum 2+SETTLE_CYCLES cycles per transaction. No overlap of transactions.
- Requests not granted are held by the requester, with no drop and no reordering per requester. Fairness: each continuously-valid requester is served within NUM_REQ transactions.
- Resp_Ready_In high before Resp_Valid_Out has no effect.
- Req_Valid_In deasserting while ungranted: legal, no effect.
- An X/Z result captured during CONVERT is passed through unchanged; the checker flags it.
- Reset mid-operation: all state and outputs return to reset values immediately and asynchronously. An in-flight request is discarded and not re-served. After release, arbitration starts from pointer 0.
- Pointer wrap: after granting NUM_REQ-1, the pointer becomes 0.

Test Plan:
1. Single request, req 0 valid, Gray 0x00000002 -> Req_Ready_Out=0001 one cycle; Resp_Id_Out=0, Resp_Binary_Data_Out=0x00000003, valid 1 cycle after accept (SETTLE_CYCLES=1).
2. Edge values on req 2: Gray 0x80000000 -> 0xFFFFFFFF; Gray 0xC0000000 -> 0x80000000; Gray 0x00000000 -> 0x00000000; Resp_Id_Out=2 each.
3. All four valid simultaneously with Gray 0x1, 0x2, 0x4, 0x8 held, Resp_Ready_In=1 -> responses ordered ID 0, 1, 2, 3 with data 0x1, 0x3, 0x7, 0xF; next round restarts at 0 after wrap.
4. Backpressure: Resp_Ready_In=0 for 5 cycles in RESPOND with req 1 valid -> Resp_Valid_Out, Resp_Id_Out and data stable, Req_Ready_Out=0000, Busy_Out=1. Once ready, req 1 is granted in the next IDLE cycle.
5. SETTLE_CYCLES=3 build: Conv_Enable_Out high for exactly 3 cycles; result captured on the 3rd edge; Gray 0x00000003 -> 0x00000002.
6. Reset asserted mid-CONVERT with pointer at 2 -> all outputs 0 within the same timestep. After release, with reqs 1 and 3 valid, req 1 is granted first.
